// File: rtl/ysyx_23060096_lsu.sv
// ---------------------------------------------------------------------------
// Module   : ysyx_23060096_lsu
// Brief    : Multi-cycle RV32 load/store unit and register-file writer.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_23060096_lsu #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [2:0]        in_funct3,
  input  logic              in_is_store,
  input  logic [REG_AW-1:0] in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t              state_q;
  logic [XLEN-1:0]     addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [3:0]          strb_q;
  logic                st_q;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic [REG_AW-1:0]   rd_q;
  logic                done_q;
  logic                err_q;
  logic [REG_AW-1:0]   rf_waddr_q;
  logic [XLEN-1:0]     rf_wdata_q;

  logic                bad_d;
  logic [3:0]          strb_d;
  logic [XLEN-1:0]     sdata_d;
  logic [XLEN-1:0]     shifted;
  logic [XLEN-1:0]     ld_d;

  // Request decode: legality/alignment plus store lane replication and strobes.
  always_comb begin
    bad_d   = 1'b0;
    strb_d  = 4'b1111;
    sdata_d = in_wdata;
    case (in_funct3)
      3'b000: begin
        strb_d  = 4'b0001 << in_addr[1:0];
        sdata_d = {4{in_wdata[7:0]}};
      end
      3'b001: begin
        bad_d   = in_addr[0];
        strb_d  = 4'b0011 << in_addr[1:0];
        sdata_d = {2{in_wdata[15:0]}};
      end
      3'b010:  bad_d = |in_addr[1:0];
      3'b100:  bad_d = in_is_store;
      3'b101:  bad_d = in_is_store | in_addr[0];
      default: bad_d = 1'b1;
    endcase
    if (!in_is_store) begin
      strb_d = 4'b0000;
    end
  end

  always_comb begin
    shifted = mem_rsp_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_d = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  ld_d = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  ld_d = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  ld_d = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_d = mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= 4'b0000;
      st_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      rd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            addr_q   <= {in_addr[XLEN-1:2], 2'b00};
            wdata_q  <= sdata_d;
            strb_q   <= strb_d;
            st_q     <= in_is_store;
            funct3_q <= in_funct3;
            off_q    <= in_addr[1:0];
            rd_q     <= in_rd;
            if (bad_d) begin
              err_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // done_q rides along into WB for loads, so both kinds retire on the same cycle count.
          if (mem_rsp_valid) begin
            done_q <= 1'b1;
            if (st_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q    <= S_WB;
              rf_waddr_q <= rd_q;
              rf_wdata_q <= ld_d;
            end
          end
        end
        S_WB:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = st_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = strb_q;
  assign rf_wen        = (state_q == S_WB) && (rd_q != '0);
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

`default_nettype wire
